// File: rtl/mem_fill_responder_pkg.sv
// Shared widths, default latency and the read-pipeline slot type for the
// main-memory fill responder.
package mem_pkg;
    localparam int ADDR_W      = 16;
    localparam int WORD_W      = 16;
    localparam int DEF_LATENCY = 4;
    localparam int DEPTH       = 2 ** (ADDR_W - 1);

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
    } slot_t;
endpackage

// File: rtl/mem_fill_responder_if.sv
// Request/response bus between the cache arbiter (master) and the responder (slave).
interface mem_fill_if;
    import mem_pkg::*;

    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic [2:0]        outstanding;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, busy, outstanding
    );
    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, busy, outstanding
    );
endinterface

// File: rtl/mem_fill_responder_delay.sv
// LATENCY-stage shift register of {valid, data} slots; reset drops every
// in-flight read.
module read_delay_line
    import mem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic  clk,
    input  logic  rst,
    input  slot_t inSlot,
    output slot_t outSlot
);
    slot_t slots [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) slots[i] <= '0;
        end else begin
            slots[0] <= inSlot;
            for (int i = 1; i < LATENCY; i++) slots[i] <= slots[i-1];
        end
    end

    assign outSlot = slots[LATENCY-1];
endmodule

// File: rtl/mem_fill_responder.sv
// Word-organised backing store with a fixed-latency pipelined read path;
// one request per cycle, never back-pressures.
module mem_fill_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic     clk,
    input  logic     rst,
    mem_fill_if.slave bus
);
    logic [WORD_W-1:0] mem [DEPTH];
    logic [ADDR_W-2:0] wordIdx;
    logic              rdAccept;
    logic              wrEn;
    slot_t             headSlot;
    slot_t             tailSlot;
    logic [2:0]        outCnt;
    logic [2:0]        outCntNext;
    logic              busyQ;

    // addr[0] is dropped, so odd addresses alias the even word below them
    assign wordIdx  = bus.addr[ADDR_W-1:1];
    assign rdAccept = bus.enable & ~bus.wr;
    assign wrEn     = bus.enable & bus.wr & rst;

    always_ff @(posedge clk) begin
        if (wrEn) mem[wordIdx] <= bus.data_in;
    end

    // Storage is sampled at the accept edge; a later write cannot touch it.
    assign headSlot.valid = rdAccept;
    assign headSlot.data  = mem[wordIdx];

    read_delay_line #(.LATENCY(LATENCY)) u_delay (
        .clk     (clk),
        .rst     (rst),
        .inSlot  (headSlot),
        .outSlot (tailSlot)
    );

    assign outCntNext = outCnt + 3'(rdAccept) - 3'(tailSlot.valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outCnt <= '0;
            busyQ  <= 1'b0;
        end else begin
            outCnt <= outCntNext;
            busyQ  <= (outCntNext != 3'd0);
        end
    end

    assign bus.data_valid  = tailSlot.valid;
    assign bus.data_out    = tailSlot.valid ? tailSlot.data : '0;
    assign bus.outstanding = outCnt;
    assign bus.busy        = busyQ;
endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench: two builds (LATENCY 4 and 1) checked every cycle against a
// queue-based response model, plus literal expectations per scenario.
module tb_mem_fill_responder;
    typedef struct {
        int          e;
        logic [15:0] d;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en  [2];
    logic        wrv [2];
    logic [15:0] ad  [2];
    logic [15:0] di  [2];
    logic        dv  [2];
    logic        bsy [2];
    logic [15:0] dout[2];
    logic [2:0]  outs[2];

    mem_fill_if ifA ();
    mem_fill_if ifB ();

    assign ifA.enable = en[0]; assign ifA.wr = wrv[0]; assign ifA.addr = ad[0]; assign ifA.data_in = di[0];
    assign ifB.enable = en[1]; assign ifB.wr = wrv[1]; assign ifB.addr = ad[1]; assign ifB.data_in = di[1];
    assign dv[0] = ifA.data_valid; assign dout[0] = ifA.data_out; assign outs[0] = ifA.outstanding; assign bsy[0] = ifA.busy;
    assign dv[1] = ifB.data_valid; assign dout[1] = ifB.data_out; assign outs[1] = ifB.outstanding; assign bsy[1] = ifB.busy;

    mem_fill_responder #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(ifA));
    mem_fill_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(ifB));

    int          lat [2] = '{4, 1};
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    rsp_t        q   [2][$];
    logic [15:0] mm  [2][32768];
    logic [15:0] vd  [2][$];
    int          vc  [2][$];
    int          maxO[2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: each accepted read is visible for exactly the cycle after edge e+L-1.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) q[d].delete();
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                while (q[d].size() > 0 && q[d][0].e + lat[d] <= cyc) void'(q[d].pop_front());
                if (en[d] && wrv[d]) mm[d][ad[d][15:1]] = di[d];
                if (en[d] && !wrv[d]) q[d].push_back('{cyc, mm[d][ad[d][15:1]]});
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        expV;
            logic [15:0] expD;
            int          expO;
            expO = q[d].size();
            expV = (expO > 0) && (q[d][0].e + lat[d] - 1 == cyc);
            expD = expV ? q[d][0].d : 16'h0;
            chk($sformatf("dut%0d.data_valid", d), 32'(dv[d]), 32'(expV));
            chk($sformatf("dut%0d.data_out", d), 32'(dout[d]), 32'(expD));
            chk($sformatf("dut%0d.outstanding", d), 32'(outs[d]), 32'(expO));
            chk($sformatf("dut%0d.busy", d), 32'(bsy[d]), 32'(expO != 0));
            if (dv[d]) begin
                vd[d].push_back(dout[d]);
                vc[d].push_back(cyc);
            end
            if (int'(outs[d]) > maxO[d]) maxO[d] = int'(outs[d]);
        end
    end

    task automatic req(input int d, input logic w, input logic [15:0] a, input logic [15:0] v);
        en[d] = 1'b1; wrv[d] = w; ad[d] = a; di[d] = v;
        @(posedge clk); #1;
        en[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clearLog(input int d);
        vd[d].delete(); vc[d].delete(); maxO[d] = 0;
    endtask

    int rdEdge;

    initial begin
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; wrv[d] = 1'b0; ad[d] = '0; di[d] = '0;
        end
        idle(3);
        chk("reset.data_valid", 32'(dv[0]), 32'd0);
        chk("reset.outstanding", 32'(outs[0]), 32'd0);
        chk("reset.data_out", 32'(dout[0]), 32'd0);
        rst = 1'b1;
        idle(2);

        // single write then read
        req(0, 1'b1, 16'h0010, 16'hBEEF);
        clearLog(0);
        req(0, 1'b0, 16'h0010, 16'h0000);
        rdEdge = cyc;
        idle(6);
        chk("single.count", 32'(vd[0].size()), 32'd1);
        chk("single.data", 32'(vd[0][0]), 32'hBEEF);
        chk("single.latency", 32'(vc[0][0] - rdEdge), 32'd3);
        chk("single.maxout", 32'(maxO[0]), 32'd1);

        // eight-word fill burst
        for (int i = 0; i < 8; i++) req(0, 1'b1, 16'(16'h0040 + 2 * i), 16'(16'h1000 + i));
        clearLog(0);
        rdEdge = cyc + 1;
        for (int i = 0; i < 8; i++) req(0, 1'b0, 16'(16'h0040 + 2 * i), 16'h0000);
        idle(6);
        chk("fill.count", 32'(vd[0].size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill.data%0d", i), 32'(vd[0][i]), 32'(16'h1000 + i));
            chk($sformatf("fill.cyc%0d", i), 32'(vc[0][i] - rdEdge), 32'(3 + i));
        end
        chk("fill.maxout", 32'(maxO[0]), 32'd4);

        // write after in-flight read
        req(0, 1'b1, 16'h0020, 16'h1111);
        clearLog(0);
        req(0, 1'b0, 16'h0020, 16'h0000);
        req(0, 1'b1, 16'h0020, 16'h2222);
        req(0, 1'b0, 16'h0020, 16'h0000);
        idle(6);
        chk("hazard.count", 32'(vd[0].size()), 32'd2);
        chk("hazard.old", 32'(vd[0][0]), 32'h1111);
        chk("hazard.new", 32'(vd[0][1]), 32'h2222);

        // odd address and top-of-memory wrap
        req(0, 1'b1, 16'hFFFF, 16'hA5A5);
        clearLog(0);
        req(0, 1'b0, 16'hFFFE, 16'h0000);
        idle(6);
        chk("wrap.count", 32'(vd[0].size()), 32'd1);
        chk("wrap.data", 32'(vd[0][0]), 32'hA5A5);

        // reset with reads in flight
        req(0, 1'b1, 16'h0030, 16'h3333);
        clearLog(0);
        req(0, 1'b0, 16'h0030, 16'h0000);
        req(0, 1'b0, 16'h0030, 16'h0000);
        en[0] = 1'b1; wrv[0] = 1'b0; ad[0] = 16'h0030;
        #2 rst = 1'b0;
        #1;
        chk("rstmid.outstanding", 32'(outs[0]), 32'd0);
        chk("rstmid.data_valid", 32'(dv[0]), 32'd0);
        chk("rstmid.busy", 32'(bsy[0]), 32'd0);
        @(posedge clk); #1;
        en[0] = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(6);
        chk("rstmid.noreturn", 32'(vd[0].size()), 32'd0);
        req(0, 1'b0, 16'h0030, 16'h0000);
        idle(5);
        chk("rstmid.retained.count", 32'(vd[0].size()), 32'd1);
        chk("rstmid.retained.data", 32'(vd[0][0]), 32'h3333);

        // LATENCY=1 build
        req(1, 1'b1, 16'h0002, 16'h7777);
        req(1, 1'b1, 16'h0004, 16'h8888);
        clearLog(1);
        rdEdge = cyc + 1;
        req(1, 1'b0, 16'h0002, 16'h0000);
        req(1, 1'b0, 16'h0004, 16'h0000);
        req(1, 1'b0, 16'h0002, 16'h0000);
        idle(3);
        chk("lat1.count", 32'(vd[1].size()), 32'd3);
        chk("lat1.data0", 32'(vd[1][0]), 32'h7777);
        chk("lat1.data1", 32'(vd[1][1]), 32'h8888);
        chk("lat1.data2", 32'(vd[1][2]), 32'h7777);
        chk("lat1.latency", 32'(vc[1][0] - rdEdge), 32'd0);
        chk("lat1.contig", 32'(vc[1][2] - vc[1][0]), 32'd2);
        chk("lat1.maxout", 32'(maxO[1]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
